// File: rtl/cache_sim_pkg.sv
// ---------------------------------------------------------------------------
// cache_sim_pkg
// Shared types and constants for the sector-cache simulation blocks.
//   mode_e    : trace pattern selector (SEQ, RAND, REUSE, reserved)
//   state_e   : trace generator run state (IDLE, RUN, DONE)
//   LFSR_TAPS : feedback taps of the 32-bit Galois LFSR
//   lfsrStep  : one right-shifting Galois step using LFSR_TAPS
// ---------------------------------------------------------------------------
package cache_sim_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ   = 2'd0,
    MODE_RAND  = 2'd1,
    MODE_REUSE = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // The bit shifted out of position 0 decides whether the taps are folded in.
  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/trace_lfsr.sv
// ---------------------------------------------------------------------------
// trace_lfsr
// 32-bit Galois LFSR supplying the pseudo-random offsets of the trace
// generator. Only instantiated when TRACE_GEN_LFSR_EN is defined.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (state returns to SEED)
//   i_load   in   reload SEED
//   i_step   in   advance one step (with i_load: state becomes step(SEED))
//   o_state  out  current LFSR state
// ---------------------------------------------------------------------------
module trace_lfsr
  import cache_sim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  output logic [31:0] o_state
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] r_state;

  // Load and step in the same cycle happens when a run starts and access 0
  // is issued at once; the register then already holds the value for access 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_EFF;
    end else if (i_load) begin
      r_state <= i_step ? lfsrStep(SEED_EFF) : SEED_EFF;
    end else if (i_step) begin
      r_state <= lfsrStep(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/cache_trace_gen.sv
// ---------------------------------------------------------------------------
// cache_trace_gen
// Programmable address-trace generator feeding the sector cache with one
// access per clock in SEQ (base + k*stride), RAND (base + masked LFSR) or
// REUSE (REUSE_REPEAT accesses per line, cycling through its sectors) mode.
// Build option: define TRACE_GEN_LFSR_EN to build RAND mode and the LFSR;
// without it mode 1 is rejected like the reserved mode.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_start        single-cycle run request (sampled in IDLE only)
//   i_mode         pattern select (mode_e)
//   i_base         base address
//   i_stride       SEQ increment in bytes
//   i_count        accesses in the run
//   i_hold         pause; no access issued while high
//   i_abort        terminate the run immediately
//   o_addr         registered access address
//   o_addr_valid   o_addr carries a real access this cycle
//   o_busy         run in progress (RUN or DONE)
//   o_done         one-cycle completion pulse
//   o_cfg_err      one-cycle pulse on a rejected start
//   o_issued       accesses issued in the current or last run
// ---------------------------------------------------------------------------
module cache_trace_gen
  import cache_sim_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          LINE_SIZE    = 32,
  parameter int          SECTOR_SIZE  = 8,
  parameter int          RAND_BITS    = 16,
  parameter int          REUSE_REPEAT = 100,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [31:0]           i_count,
  input  logic                  i_hold,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_addr_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err,
  output logic [31:0]           o_issued
);

  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(LINE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] SECT_BYTES = ADDR_WIDTH'(SECTOR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(LINE_SIZE - 1);
  localparam logic [31:0]           REP_LAST   = 32'(REUSE_REPEAT - 1);

  state_e                r_state, w_nextState;
  mode_e                 r_mode;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_seqAcc;
  logic [ADDR_WIDTH-1:0] r_lineBase;
  logic [ADDR_WIDTH-1:0] r_sectOff;
  logic [31:0]           r_repCnt;
  logic [31:0]           r_count;
  logic [31:0]           r_issued;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_addrValid;
  logic                  r_done;
  logic                  r_cfgErr;

  logic                  w_modeLegal;
  logic                  w_load;
  logic                  w_issue;
  logic                  w_finish;
  logic                  w_cfgErr;

  mode_e                 w_curMode;
  logic [ADDR_WIDTH-1:0] w_curStride;
  logic [ADDR_WIDTH-1:0] w_curSeq;
  logic [ADDR_WIDTH-1:0] w_curLine;
  logic [ADDR_WIDTH-1:0] w_curSect;
  logic [31:0]           w_curRep;
  logic [ADDR_WIDTH-1:0] w_curAddr;

  logic [ADDR_WIDTH-1:0] w_advSeq;
  logic [ADDR_WIDTH-1:0] w_advLine;
  logic [ADDR_WIDTH-1:0] w_advSect;
  logic [31:0]           w_advRep;
  logic                  w_repWrap;

`ifdef TRACE_GEN_LFSR_EN
  localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] RAND_MASK = 32'((64'd1 << RAND_BITS) - 64'd1);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] w_curBase;
  logic [31:0]           w_lfsrState;
  logic [31:0]           w_curLfsr;

  trace_lfsr #(
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_issue),
    .o_state (w_lfsrState)
  );

  assign w_curBase = w_load ? i_base : r_base;
  assign w_curLfsr = w_load ? SEED_EFF : w_lfsrState;
`endif

  always_comb begin
    w_modeLegal = 1'b0;
    case (mode_e'(i_mode))
      MODE_SEQ:   w_modeLegal = 1'b1;
      MODE_REUSE: w_modeLegal = 1'b1;
`ifdef TRACE_GEN_LFSR_EN
      MODE_RAND:  w_modeLegal = 1'b1;
`endif
      default:    w_modeLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Access k is issued on the edge that makes it visible in the following
  // cycle, so the accepting start edge already issues access 0 (unless held).
  // In RUN, issued == count means every access is out and the run completes.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    w_cfgErr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_modeLegal) begin
            w_load = 1'b1;
            if (i_count == 32'd0) begin
              w_nextState = ST_DONE;
              w_finish    = 1'b1;
            end else begin
              w_nextState = ST_RUN;
              w_issue     = ~i_hold;
            end
          end else begin
            w_cfgErr = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_nextState = ST_IDLE;
        end else if (r_issued == r_count) begin
          w_nextState = ST_DONE;
          w_finish    = 1'b1;
        end else begin
          w_issue = ~i_hold;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // On the start edge the running values are taken straight from the
  // inputs, so access 0 is available without an extra setup cycle.
  assign w_curMode   = w_load ? mode_e'(i_mode) : r_mode;
  assign w_curStride = w_load ? i_stride : r_stride;
  assign w_curSeq    = w_load ? i_base   : r_seqAcc;
  assign w_curLine   = w_load ? i_base   : r_lineBase;
  assign w_curSect   = w_load ? '0       : r_sectOff;
  assign w_curRep    = w_load ? 32'd0    : r_repCnt;

  // The sector offset cycles independently of the line counter, so it
  // keeps counting across line changes rather than restarting at zero.
  assign w_advSeq  = w_curSeq + w_curStride;
  assign w_advSect = (w_curSect + SECT_BYTES) & OFF_MASK;
  assign w_repWrap = (w_curRep == REP_LAST);
  assign w_advRep  = w_repWrap ? 32'd0 : (w_curRep + 32'd1);
  assign w_advLine = w_repWrap ? (w_curLine + LINE_BYTES) : w_curLine;

  always_comb begin
    w_curAddr = w_curSeq;
    case (w_curMode)
      MODE_REUSE: w_curAddr = w_curLine + w_curSect;
`ifdef TRACE_GEN_LFSR_EN
      MODE_RAND:  w_curAddr = w_curBase + ADDR_WIDTH'(w_curLfsr & RAND_MASK);
`endif
      default:    w_curAddr = w_curSeq;
    endcase
  end

  // Running pattern state advances only on an issued access; a held start
  // still loads the initial values so the run resumes at access 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_SEQ;
      r_stride    <= '0;
      r_count     <= 32'd0;
      r_seqAcc    <= '0;
      r_lineBase  <= '0;
      r_sectOff   <= '0;
      r_repCnt    <= 32'd0;
      r_issued    <= 32'd0;
      r_addr      <= '0;
      r_addrValid <= 1'b0;
      r_done      <= 1'b0;
      r_cfgErr    <= 1'b0;
    end else begin
      r_addrValid <= w_issue;
      r_done      <= w_finish;
      r_cfgErr    <= w_cfgErr;
      if (w_issue) begin
        r_addr <= w_curAddr;
      end
      if (w_load) begin
        r_mode   <= mode_e'(i_mode);
        r_stride <= i_stride;
        r_count  <= i_count;
        r_issued <= w_issue ? 32'd1 : 32'd0;
      end else if (w_issue) begin
        r_issued <= r_issued + 32'd1;
      end
      if (w_load || w_issue) begin
        r_seqAcc   <= w_issue ? w_advSeq  : w_curSeq;
        r_lineBase <= w_issue ? w_advLine : w_curLine;
        r_sectOff  <= w_issue ? w_advSect : w_curSect;
        r_repCnt   <= w_issue ? w_advRep  : w_curRep;
      end
    end
  end

`ifdef TRACE_GEN_LFSR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
    end else if (w_load) begin
      r_base <= i_base;
    end
  end
`endif

  assign o_addr       = r_addr;
  assign o_addr_valid = r_addrValid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_cfg_err    = r_cfgErr;
  assign o_issued     = r_issued;

endmodule

// File: tb/tb_cache_trace_gen.sv
// ---------------------------------------------------------------------------
// tb_cache_trace_gen
// Directed self-checking bench for cache_trace_gen. Inputs are driven and
// outputs sampled on the falling edge; each scenario task holds its own
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cache_trace_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] base;
  logic [31:0] stride;
  logic [31:0] count;
  logic        hold;
  logic        abort;
  logic [31:0] addr;
  logic        addrValid;
  logic        busy;
  logic        done;
  logic        cfgErr;
  logic [31:0] issued;

  int checkCount = 0;
  int passCount  = 0;

  cache_trace_gen dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_mode       (mode),
    .i_base       (base),
    .i_stride     (stride),
    .i_count      (count),
    .i_hold       (hold),
    .i_abort      (abort),
    .o_addr       (addr),
    .o_addr_valid (addrValid),
    .o_busy       (busy),
    .o_done       (done),
    .o_cfg_err    (cfgErr),
    .o_issued     (issued)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence of tasks ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One-cycle start pulse; returns in the middle of the first cycle after
  // the accepting edge (cycle T+1).
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] b,
                               input logic [31:0] s, input logic [31:0] c);
    @(negedge clk);
    mode = m; base = b; stride = s; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 2'd0; base = '0; stride = '0;
    count = '0; hold = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++; if (addr !== 32'd0) $display("[TB] FAIL reset_addr: got %h want 0", addr); else passCount++;
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", addrValid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passCount++;
    checkCount++; if (cfgErr !== 1'b0) $display("[TB] FAIL reset_cfgerr: got %b want 0", cfgErr); else passCount++;
    checkCount++; if (issued !== 32'd0) $display("[TB] FAIL reset_issued: got %0d want 0", issued); else passCount++;
    rst = 1'b0;
    @(negedge clk);
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); else passCount++;
  endtask

  task automatic test_seq();
    applyStimulus(2'd0, 32'd0, 32'd8, 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkCount++; if (addrValid !== 1'b1) $display("[TB] FAIL seq_valid k=%0d: got %b want 1", k, addrValid); else passCount++;
      checkCount++; if (addr !== 32'(8 * k)) $display("[TB] FAIL seq_addr k=%0d: got %h want %h", k, addr, 32'(8 * k)); else passCount++;
      checkCount++; if (busy !== 1'b1) $display("[TB] FAIL seq_busy k=%0d: got %b want 1", k, busy); else passCount++;
      @(negedge clk);
    end
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL seq_done: got %b want 1", done); else passCount++;
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL seq_done_valid: got %b want 0", addrValid); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL seq_done_busy: got %b want 1", busy); else passCount++;
    checkCount++; if (issued !== 32'd4) $display("[TB] FAIL seq_issued: got %0d want 4", issued); else passCount++;
    @(negedge clk);
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL seq_done_pulse: got %b want 0", done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL seq_idle_busy: got %b want 0", busy); else passCount++;
  endtask

  task automatic test_reuse();
    logic [31:0] expAddr;
    applyStimulus(2'd2, 32'd0, 32'd0, 32'd101);
    for (int k = 0; k < 101; k++) begin
      // 100 accesses per 32-byte line, 4 sectors of 8 bytes cycling.
      expAddr = 32'((k / 100) * 32 + (k % 4) * 8);
      checkCount++; if (addr !== expAddr || addrValid !== 1'b1) $display("[TB] FAIL reuse_addr k=%0d: got %h/%b want %h/1", k, addr, addrValid, expAddr); else passCount++;
      @(negedge clk);
    end
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL reuse_done: got %b want 1", done); else passCount++;
    checkCount++; if (issued !== 32'd101) $display("[TB] FAIL reuse_issued: got %0d want 101", issued); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_rand();
`ifdef TRACE_GEN_LFSR_EN
    logic [31:0] s;
    logic [31:0] firstRun [16];
    s = 32'hACE1_2468;
    applyStimulus(2'd1, 32'h0001_0000, 32'd0, 32'd16);
    checkCount++; if (addr !== 32'h0001_2468) $display("[TB] FAIL rand_first: got %h want 00012468", addr); else passCount++;
    for (int k = 0; k < 16; k++) begin
      checkCount++; if (addr !== (32'h0001_0000 + (s & 32'h0000_FFFF))) $display("[TB] FAIL rand_addr k=%0d: got %h want %h", k, addr, 32'h0001_0000 + (s & 32'h0000_FFFF)); else passCount++;
      checkCount++; if (addr[31:16] !== 16'h0001) $display("[TB] FAIL rand_window k=%0d: got %h want 0001xxxx", k, addr); else passCount++;
      firstRun[k] = 32'h0001_0000 + (s & 32'h0000_FFFF);
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      @(negedge clk);
    end
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL rand_done: got %b want 1", done); else passCount++;
    @(negedge clk);
    applyStimulus(2'd1, 32'h0001_0000, 32'd0, 32'd16);
    for (int k = 0; k < 16; k++) begin
      checkCount++; if (addr !== firstRun[k]) $display("[TB] FAIL rand_repeat k=%0d: got %h want %h", k, addr, firstRun[k]); else passCount++;
      @(negedge clk);
    end
    @(negedge clk);
`else
    applyStimulus(2'd1, 32'h0001_0000, 32'd0, 32'd4);
    checkCount++; if (cfgErr !== 1'b1) $display("[TB] FAIL rand_disabled_cfgerr: got %b want 1", cfgErr); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rand_disabled_busy: got %b want 0", busy); else passCount++;
    @(negedge clk);
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL rand_disabled_valid: got %b want 0", addrValid); else passCount++;
`endif
  endtask

  task automatic test_wrap();
    applyStimulus(2'd0, 32'hFFFF_FFF8, 32'd8, 32'd2);
    checkCount++; if (addr !== 32'hFFFF_FFF8) $display("[TB] FAIL wrap_0: got %h want fffffff8", addr); else passCount++;
    @(negedge clk);
    checkCount++; if (addr !== 32'h0000_0000 || addrValid !== 1'b1) $display("[TB] FAIL wrap_1: got %h/%b want 00000000/1", addr, addrValid); else passCount++;
    @(negedge clk);
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL wrap_done: got %b want 1", done); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_hold();
    applyStimulus(2'd0, 32'h0000_0100, 32'd4, 32'd6);
    checkCount++; if (addr !== 32'h100) $display("[TB] FAIL hold_k0: got %h want 100", addr); else passCount++;
    @(negedge clk);
    checkCount++; if (addr !== 32'h104) $display("[TB] FAIL hold_k1: got %h want 104", addr); else passCount++;
    hold = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL hold_bubble%0d_valid: got %b want 0", b, addrValid); else passCount++;
      checkCount++; if (addr !== 32'h104) $display("[TB] FAIL hold_bubble%0d_addr: got %h want 104", b, addr); else passCount++;
      checkCount++; if (issued !== 32'd2) $display("[TB] FAIL hold_bubble%0d_issued: got %0d want 2", b, issued); else passCount++;
    end
    hold = 1'b0;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      checkCount++; if (addr !== 32'(32'h100 + 4 * k) || addrValid !== 1'b1) $display("[TB] FAIL hold_resume k=%0d: got %h/%b want %h/1", k, addr, addrValid, 32'(32'h100 + 4 * k)); else passCount++;
    end
    @(negedge clk);
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL hold_done: got %b want 1", done); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    applyStimulus(2'd0, 32'h0000_2000, 32'd16, 32'd10);
    @(negedge clk);
    checkCount++; if (issued !== 32'd2) $display("[TB] FAIL abort_pre_issued: got %0d want 2", issued); else passCount++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passCount++;
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL abort_valid: got %b want 0", addrValid); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b want 0", done); else passCount++;
    checkCount++; if (issued !== 32'd2) $display("[TB] FAIL abort_issued: got %0d want 2", issued); else passCount++;
    @(negedge clk);
    checkCount++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL abort_after: got done=%b busy=%b want 0/0", done, busy); else passCount++;
  endtask

  task automatic test_count_zero();
    applyStimulus(2'd0, 32'h0000_4000, 32'd4, 32'd0);
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b want 1", done); else passCount++;
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL zero_valid: got %b want 0", addrValid); else passCount++;
    checkCount++; if (issued !== 32'd0) $display("[TB] FAIL zero_issued: got %0d want 0", issued); else passCount++;
    @(negedge clk);
    checkCount++; if (done !== 1'b0 || busy !== 1'b0 || addrValid !== 1'b0) $display("[TB] FAIL zero_after: got done=%b busy=%b valid=%b want 0/0/0", done, busy, addrValid); else passCount++;
  endtask

  task automatic test_cfg_err();
    applyStimulus(2'd3, 32'h0000_0000, 32'd4, 32'd4);
    checkCount++; if (cfgErr !== 1'b1) $display("[TB] FAIL cfgerr_pulse: got %b want 1", cfgErr); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL cfgerr_busy: got %b want 0", busy); else passCount++;
    @(negedge clk);
    checkCount++; if (cfgErr !== 1'b0) $display("[TB] FAIL cfgerr_clear: got %b want 0", cfgErr); else passCount++;
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL cfgerr_valid: got %b want 0", addrValid); else passCount++;
  endtask

  task automatic test_start_during_run();
    applyStimulus(2'd0, 32'd0, 32'd1, 32'd5);
    @(negedge clk);
    mode = 2'd2; base = 32'h0000_5000; count = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkCount++; if (addr !== 32'd2 || addrValid !== 1'b1) $display("[TB] FAIL restart_k2: got %h/%b want 2/1", addr, addrValid); else passCount++;
    @(negedge clk);
    @(negedge clk);
    checkCount++; if (addr !== 32'd4) $display("[TB] FAIL restart_k4: got %h want 4", addr); else passCount++;
    @(negedge clk);
    checkCount++; if (done !== 1'b1 || issued !== 32'd5) $display("[TB] FAIL restart_done: got done=%b issued=%0d want 1/5", done, issued); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    applyStimulus(2'd0, 32'h0000_0040, 32'd4, 32'd10);
    @(negedge clk);
    @(negedge clk);
    checkCount++; if (addr !== 32'h48) $display("[TB] FAIL midrst_pre: got %h want 48", addr); else passCount++;
    #2 rst = 1'b1;
    #1;
    checkCount++; if (addr !== 32'd0) $display("[TB] FAIL midrst_addr: got %h want 0", addr); else passCount++;
    checkCount++; if (addrValid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b want 0", addrValid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passCount++;
    checkCount++; if (issued !== 32'd0) $display("[TB] FAIL midrst_issued: got %0d want 0", issued); else passCount++;
    checkCount++; if (done !== 1'b0 || cfgErr !== 1'b0) $display("[TB] FAIL midrst_pulses: got done=%b cfg_err=%b want 0/0", done, cfgErr); else passCount++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkCount++; if (busy !== 1'b0 || addrValid !== 1'b0) $display("[TB] FAIL midrst_after: got busy=%b valid=%b want 0/0", busy, addrValid); else passCount++;
  endtask

  initial begin
    $display("[TB] cache_trace_gen directed bench");
    test_reset();
    test_seq();
    test_reuse();
    test_rand();
    test_wrap();
    test_hold();
    test_abort();
    test_count_zero();
    test_cfg_err();
    test_start_during_run();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
